// File: rtl/pwm_ref_gen.sv
// pwm_ref_gen: multi-channel threshold-compare PWM reference with shadowed, wrap-aligned updates.
// Optional feature macro PWM_REF_RAMP_EN: each channel ramps 1 LSB per period toward its level.
module pwm_ref_gen #(
    parameter int CNT_W      = 17,
    parameter int PERIOD     = 100000,
    parameter int REF_W      = 5,
    parameter int NCH        = 2,
    parameter int THRESH_DEF = 80000,
    parameter int LEVEL_DEF  = 6
) (
    input  logic                 clk,
    input  logic                 reset_central,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2:0]           cfg_ch,
    input  logic [CNT_W-1:0]     cfg_thresh,
    input  logic [REF_W-1:0]     cfg_level,
    output logic [CNT_W-1:0]     contador,
    output logic                 period_tick,
    output logic [NCH*REF_W-1:0] pwm_ref
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'(THRESH_DEF);
    localparam logic [REF_W-1:0] LVL_RST = REF_W'(LEVEL_DEF);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          pend_q, pend_d;
    logic [2:0]                    sh_ch_q, sh_ch_d;
    logic [CNT_W-1:0]              sh_thr_q, sh_thr_d;
    logic [REF_W-1:0]              sh_lvl_q, sh_lvl_d;
    logic [NCH-1:0][CNT_W-1:0]     thr_q, thr_d;
    logic [NCH-1:0][REF_W-1:0]     lvl_q, lvl_d;
    logic [NCH*REF_W-1:0]          pwm_q, pwm_d;
    logic [NCH-1:0][REF_W-1:0]     drive;
    logic                          run, go, xfer, apply;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        run         = (state_q == RUN);
        go          = run && enable;
        period_tick = run && (cnt_q == LAST);
        cfg_ready   = !pend_q;
        xfer        = cfg_valid && !pend_q;
        // Outside RUN there is no wrap to wait for, so a pending update lands on the next edge.
        apply       = pend_q && (period_tick || !run);

        cnt_d = '0;
        if (go) cnt_d = period_tick ? '0 : cnt_q + CNT_W'(1);

        sh_ch_d  = sh_ch_q;
        sh_thr_d = sh_thr_q;
        sh_lvl_d = sh_lvl_q;
        pend_d   = pend_q;
        if (xfer) begin
            sh_ch_d  = cfg_ch;
            sh_thr_d = cfg_thresh;
            sh_lvl_d = cfg_level;
            pend_d   = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end

        // Channel numbers at or above NCH match no entry and are simply dropped.
        thr_d = thr_q;
        lvl_d = lvl_q;
        for (int c = 0; c < NCH; c++) begin
            if (apply && (sh_ch_q == 3'(c))) begin
                thr_d[c] = sh_thr_q;
                lvl_d[c] = sh_lvl_q;
            end
        end

        pwm_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (go && (cnt_q >= thr_q[c])) pwm_d[c*REF_W +: REF_W] = drive[c];
        end
    end

`ifdef PWM_REF_RAMP_EN
    logic [NCH-1:0][REF_W-1:0] cur_q, cur_d;

    always_comb begin
        cur_d = cur_q;
        for (int c = 0; c < NCH; c++) begin
            if (!go)                                        cur_d[c] = '0;
            else if (period_tick && (cur_q[c] < lvl_q[c]))  cur_d[c] = cur_q[c] + REF_W'(1);
            else if (period_tick && (cur_q[c] > lvl_q[c]))  cur_d[c] = cur_q[c] - REF_W'(1);
        end
        drive = cur_q;
    end

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) cur_q <= '0;
        else               cur_q <= cur_d;
    end
`else
    always_comb drive = lvl_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only; the active config registers are
    // reset to their defaults because the outputs depend on them from the first RUN cycle.
    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            sh_ch_q  <= '0;
            sh_thr_q <= '0;
            sh_lvl_q <= '0;
            thr_q    <= {NCH{THR_RST}};
            lvl_q    <= {NCH{LVL_RST}};
            pwm_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            sh_ch_q  <= sh_ch_d;
            sh_thr_q <= sh_thr_d;
            sh_lvl_q <= sh_lvl_d;
            thr_q    <= thr_d;
            lvl_q    <= lvl_d;
            pwm_q    <= pwm_d;
        end
    end

    assign contador = cnt_q;
    assign pwm_ref  = pwm_q;

endmodule

// File: tb/tb_pwm_ref_gen.sv
// tb_pwm_ref_gen: vector table, directed corner sequences and randomized traffic for pwm_ref_gen,
// all checked against a period-level behavioural model of the reference generator.
module tb_pwm_ref_gen;
    localparam int CNT_W   = 5;
    localparam int PERIOD  = 16;
    localparam int REF_W   = 5;
    localparam int NCH     = 2;
    localparam int THR_DEF = 10;
    localparam int LVL_DEF = 6;
    localparam int NROWS   = 34;

    logic                 clk = 1'b0;
    logic                 reset_central;
    logic                 enable;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [2:0]           cfg_ch;
    logic [CNT_W-1:0]     cfg_thresh;
    logic [REF_W-1:0]     cfg_level;
    logic [CNT_W-1:0]     contador;
    logic                 period_tick;
    logic [NCH*REF_W-1:0] pwm_ref;

    int n_checks = 0;
    int n_errors = 0;

    pwm_ref_gen #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .REF_W(REF_W), .NCH(NCH),
        .THRESH_DEF(THR_DEF), .LEVEL_DEF(LVL_DEF)
    ) dut (
        .clk(clk), .reset_central(reset_central), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_thresh(cfg_thresh), .cfg_level(cfg_level), .contador(contador),
        .period_tick(period_tick), .pwm_ref(pwm_ref)
    );

    always #5 clk = ~clk;

    // Behavioural model: running flag, count, one shadow slot, per-channel settings.
    bit m_run, m_pend;
    int m_cnt, m_sch, m_sthr, m_slvl;
    int m_thr[NCH], m_lvl[NCH], m_cur[NCH], m_pwm[NCH];

    typedef struct {
        bit en;
        int e_cnt;
        bit e_tick;
        bit e_ready;
        int e_ch0;
        int e_ch1;
    } vec_t;
    vec_t tbl[NROWS];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int ch_of(input int c);
        logic [NCH*REF_W-1:0] v;
        v = pwm_ref;
        return int'(v[c*REF_W +: REF_W]);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_cnt = 0;
        m_sch = 0; m_sthr = 0; m_slvl = 0;
        for (int c = 0; c < NCH; c++) begin
            m_thr[c] = THR_DEF; m_lvl[c] = LVL_DEF; m_cur[c] = 0; m_pwm[c] = 0;
        end
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_advance();
        bit go, wrap, take, land;
        go   = m_run && enable;
        wrap = m_run && (m_cnt == PERIOD - 1);
        take = cfg_valid && !m_pend;
        land = m_pend && (wrap || !m_run);
        for (int c = 0; c < NCH; c++) begin
`ifdef PWM_REF_RAMP_EN
            m_pwm[c] = (go && m_cnt >= m_thr[c]) ? m_cur[c] : 0;
            if (!go) m_cur[c] = 0;
            else if (wrap && m_cur[c] < m_lvl[c]) m_cur[c]++;
            else if (wrap && m_cur[c] > m_lvl[c]) m_cur[c]--;
`else
            m_pwm[c] = (go && m_cnt >= m_thr[c]) ? m_lvl[c] : 0;
`endif
        end
        if (land && m_sch < NCH) begin
            m_thr[m_sch] = m_sthr;
            m_lvl[m_sch] = m_slvl;
        end
        if (take) begin
            m_pend = 1; m_sch = int'(cfg_ch); m_sthr = int'(cfg_thresh); m_slvl = int'(cfg_level);
        end else if (land) begin
            m_pend = 0;
        end
        m_cnt = go ? (m_cnt + 1) % PERIOD : 0;
        m_run = enable;
    endtask

    task automatic compare_model();
        check("contador", int'(contador), m_cnt);
        check("period_tick", int'(period_tick), int'(m_run && m_cnt == PERIOD - 1));
        check("cfg_ready", int'(cfg_ready), int'(!m_pend));
        for (int c = 0; c < NCH; c++) check($sformatf("pwm_ch%0d", c), ch_of(c), m_pwm[c]);
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 4 * PERIOD && int'(contador) != target; i++) step();
        check("reach_count", int'(contador), target);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected waveform after enable: count k mod PERIOD, output reflects the previous count.
        for (int k = 0; k < NROWS; k++) begin
            int prev, lvl_now;
            prev = k - 1;
`ifdef PWM_REF_RAMP_EN
            lvl_now = (k >= 1) ? min_i(prev / PERIOD, LVL_DEF) : 0;
`else
            lvl_now = LVL_DEF;
`endif
            tbl[k].en      = 1'b1;
            tbl[k].e_cnt   = k % PERIOD;
            tbl[k].e_tick  = (k % PERIOD) == PERIOD - 1;
            tbl[k].e_ready = 1'b1;
            tbl[k].e_ch0   = (k >= 1 && (prev % PERIOD) >= THR_DEF) ? lvl_now : 0;
            tbl[k].e_ch1   = tbl[k].e_ch0;
        end

        reset_central = 1'b1;
        enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_thresh = '0; cfg_level = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_contador", int'(contador), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_pwm", int'(pwm_ref), 0);
        reset_central = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            enable = tbl[i].en;
            step();
            check("tbl_cnt", int'(contador), tbl[i].e_cnt);
            check("tbl_tick", int'(period_tick), int'(tbl[i].e_tick));
            check("tbl_ready", int'(cfg_ready), int'(tbl[i].e_ready));
            check("tbl_ch0", ch_of(0), tbl[i].e_ch0);
            check("tbl_ch1", ch_of(1), tbl[i].e_ch1);
        end

        // Shadowed update of ch1; a held request while busy must not be consumed.
        run_until(7);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_thresh = 5'd4; cfg_level = 5'd9;
        step();
        check("busy_after_xfer", int'(cfg_ready), 0);
        cfg_ch = 3'd0; cfg_thresh = 5'd0; cfg_level = 5'd31;
        step();
        step();
        cfg_valid = 1'b0;
        run_until(0);
        check("ready_at_wrap", int'(cfg_ready), 1);
        run_until(5);
`ifndef PWM_REF_RAMP_EN
        check("ch1_new_level", ch_of(1), 9);
        check("ch0_unchanged", ch_of(0), 0);
`endif

        // Out-of-range channel: accepted, then discarded.
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_thresh = 5'd0; cfg_level = 5'd1;
        step();
        cfg_valid = 1'b0;
        check("oob_busy", int'(cfg_ready), 0);
        run_until(0);
        check("oob_ready", int'(cfg_ready), 1);

        // Drop enable mid-period, then restart from zero.
        run_until(12);
        enable = 1'b0;
        step();
        check("drop_cnt", int'(contador), 0);
        check("drop_pwm", int'(pwm_ref), 0);
        step();
        enable = 1'b1;
        step();
        check("restart_cnt0", int'(contador), 0);
        step();
        check("restart_cnt1", int'(contador), 1);

        // Asynchronous reset with an update pending.
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_thresh = 5'd2; cfg_level = 5'd15;
        step();
        cfg_valid = 1'b0;
        check("pend_before_rst", int'(cfg_ready), 0);
        #3 reset_central = 1'b1;
        #1;
        check("arst_cnt", int'(contador), 0);
        check("arst_pwm", int'(pwm_ref), 0);
        check("arst_ready", int'(cfg_ready), 1);
        check("arst_tick", int'(period_tick), 0);
        model_reset();
        enable = 1'b0;
        @(posedge clk);
        #1 reset_central = 1'b0;
        enable = 1'b1;
        step();
        run_until(5);
        check("rst_thr_ch0_low", ch_of(0), 0);
        run_until(12);
`ifndef PWM_REF_RAMP_EN
        check("rst_thr_ch0_high", ch_of(0), LVL_DEF);
`endif

`ifdef PWM_REF_RAMP_EN
        // Ramp: level 3, threshold 0 yields 0,1,2,3,3 over successive periods.
        enable = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_thresh = 5'd0; cfg_level = 5'd3;
        step();
        cfg_valid = 1'b0;
        step();
        enable = 1'b1;
        step();
        for (int p = 0; p < 5; p++) begin
            run_until(3);
            check("ramp_ch0", ch_of(0), min_i(p, 3));
            step();
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 99) < 97);
            cfg_valid  = ($urandom_range(0, 99) < 25);
            cfg_ch     = 3'($urandom_range(0, 7));
            cfg_thresh = CNT_W'($urandom_range(0, 31));
            cfg_level  = REF_W'($urandom_range(0, 31));
            step();
        end
        cfg_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
